// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) layout: codeword bit positions, widths and parity-sense encoding.
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  // Bit index in the codeword for each Hamming position (position = index + 1).
  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int D0_IDX = 2;
  localparam int P4_IDX = 3;
  localparam int D1_IDX = 4;
  localparam int D2_IDX = 5;
  localparam int D3_IDX = 6;

  localparam logic MODE_EVEN = 1'b1;
  localparam logic MODE_ODD  = 1'b0;

  // Pull the payload {d3,d2,d1,d0} out of a codeword.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    return {code[D3_IDX], code[D2_IDX], code[D1_IDX], code[D0_IDX]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome of a 7-bit codeword; odd-parity words get every check bit inverted.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic              mode,
  output logic [SYN_W-1:0]  syndrome
);

  logic s1;
  logic s2;
  logic s4;

  assign s1 = code[P1_IDX] ^ code[D0_IDX] ^ code[D1_IDX] ^ code[D3_IDX];
  assign s2 = code[P2_IDX] ^ code[D0_IDX] ^ code[D2_IDX] ^ code[D3_IDX];
  assign s4 = code[P4_IDX] ^ code[D1_IDX] ^ code[D2_IDX] ^ code[D3_IDX];

  assign syndrome = {s4, s2, s1} ^ ((mode == MODE_EVEN) ? 3'b000 : 3'b111);

endmodule

// File: rtl/hamming_checker.sv
// Hamming(7,4) receiver: stage 1 computes the syndrome, stage 2 corrects and emits the payload.
// A saturating counter tracks how many delivered words needed correction.
module hamming_checker
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic [CODE_W-1:0] code_in,
  input  logic              clr_count,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              err_flag,
  output logic [SYN_W-1:0]  syndrome_out,
  output logic [CNT_W-1:0]  err_count
);

  logic [SYN_W-1:0]  syn_comb;
  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [SYN_W-1:0]  s1_syn;
  logic [CODE_W-1:0] fixed_code;
  logic              s1_err;

  hamming_syndrome u_syndrome (
    .code     (code_in),
    .mode     (mode),
    .syndrome (syn_comb)
  );

  // Stage 1: capture the word with its mode-adjusted syndrome; data regs only load on enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else begin
      s1_valid <= enable;
      if (enable) begin
        s1_code <= code_in;
        s1_syn  <= syn_comb;
      end
    end
  end

  assign s1_err = (s1_syn != '0);

  // Flip the bit the syndrome points at; a zero syndrome matches no position.
  always_comb begin
    fixed_code = s1_code;
    for (int i = 0; i < CODE_W; i++) begin
      if (s1_syn == SYN_W'(i + 1)) fixed_code[i] = ~s1_code[i];
    end
  end

  // Stage 2: register results for completing words, hold the previous result otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out    <= 1'b0;
      data_out     <= '0;
      err_flag     <= 1'b0;
      syndrome_out <= '0;
    end else begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        data_out     <= extract_data(fixed_code);
        err_flag     <= s1_err;
        syndrome_out <= s1_syn;
      end
    end
  end

  // Count corrected words as they complete; clear takes priority, counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      err_count <= '0;
    end else if (s1_valid && s1_err && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule
